dct_2d_sched: RTL and testbench

Scheduler that time-shares one `dct_1d` instance between the row pass and the column pass of an 8x8 2D-DCT. It accepts 8x8 pixel blocks as 8 row vectors, feeds them to the shared 1D-DCT, and captures the 64 row results into an internal transpose buffer. It then feeds the 8 buffered columns back through the same 1D-DCT and forwards the column results downstream as the final 2D coefficients. It sits between the blocking stage and quantization/zig-zag.

---
 rtl/dct_2d_sched.sv | 135 +++++++++++++
 tb/tb_dct_2d_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_2d_sched.sv
// Time-shares one 1D-DCT between the row and column passes of an 8x8 2D-DCT,
// transposing through a single 64-word buffer; all handshake paths are combinational.
module dct_2d_sched #(
  parameter int unsigned PX_WIDTH  = 8,
  parameter int unsigned DCT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [8*PX_WIDTH-1:0]  video_i_tdata,
  input  logic                   video_i_tvalid,
  input  logic                   video_i_tuser,
  output logic                   video_i_tready,
  output logic [8*DCT_WIDTH-1:0] dct_req_o_tdata,
  output logic                   dct_req_o_tvalid,
  input  logic                   dct_req_o_tready,
  input  logic [DCT_WIDTH-1:0]   dct_res_i_tdata,
  input  logic                   dct_res_i_tvalid,
  output logic                   dct_res_i_tready,
  output logic [DCT_WIDTH-1:0]   coef_o_tdata,
  output logic                   coef_o_tvalid,
  output logic                   coef_o_tlast,
  output logic                   coef_o_tuser,
  input  logic                   coef_o_tready
);

  localparam int unsigned LANES = 8;

  localparam logic [0:0] ROW_PASS = 1'b0;
  localparam logic [0:0] COL_PASS = 1'b1;

  logic [0:0]           state;
  logic [0:0]           next_state;
  logic [3:0]           feed_cnt;
  logic [5:0]           res_cnt;
  logic [5:0]           out_cnt;
  logic                 sof_flag;
  logic                 feeding;
  logic                 req_hs;
  logic                 res_hs;
  logic                 coef_hs;
  logic [DCT_WIDTH-1:0] tbuf [LANES][LANES];

  assign feeding = ~feed_cnt[3];
  assign req_hs  = dct_req_o_tvalid & dct_req_o_tready;
  assign res_hs  = dct_res_i_tvalid & dct_res_i_tready;
  assign coef_hs = coef_o_tvalid & coef_o_tready;

  // Handshake routing and next state; reset gates the row-pass forwarding paths.
  always_comb begin
    next_state       = state;
    video_i_tready   = 1'b0;
    dct_req_o_tvalid = 1'b0;
    dct_req_o_tdata  = '0;
    dct_res_i_tready = 1'b0;
    coef_o_tvalid    = 1'b0;
    coef_o_tlast     = 1'b0;
    coef_o_tuser     = 1'b0;
    coef_o_tdata     = dct_res_i_tdata;
    case (state)
      ROW_PASS: begin
        for (int i = 0; i < 8; i++) begin
          dct_req_o_tdata[i*DCT_WIDTH +: DCT_WIDTH] =
            DCT_WIDTH'($signed(video_i_tdata[i*PX_WIDTH +: PX_WIDTH]));
        end
        if (!rst_i) begin
          dct_res_i_tready = 1'b1;
          if (feeding) begin
            video_i_tready   = dct_req_o_tready;
            dct_req_o_tvalid = video_i_tvalid;
          end
        end
        if (dct_res_i_tvalid && dct_res_i_tready && (res_cnt == 6'd63)) begin
          next_state = COL_PASS;
        end
      end
      default: begin
        // Column j of the transpose: lane i comes from row result i, word j.
        for (int i = 0; i < 8; i++) begin
          dct_req_o_tdata[i*DCT_WIDTH +: DCT_WIDTH] = tbuf[i][feed_cnt[2:0]];
        end
        dct_req_o_tvalid = feeding;
        coef_o_tvalid    = dct_res_i_tvalid;
        dct_res_i_tready = coef_o_tready;
        coef_o_tlast     = (out_cnt == 6'd63);
        coef_o_tuser     = (out_cnt == 6'd0) && sof_flag;
        if (dct_res_i_tvalid && coef_o_tready && (out_cnt == 6'd63)) begin
          next_state = ROW_PASS;
        end
      end
    endcase
  end

  // State, counters and start-of-frame flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ROW_PASS;
      feed_cnt <= '0;
      res_cnt  <= '0;
      out_cnt  <= '0;
      sof_flag <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == ROW_PASS) && (next_state == COL_PASS)) begin
        feed_cnt <= '0;
        res_cnt  <= '0;
      end else if ((state == COL_PASS) && (next_state == ROW_PASS)) begin
        feed_cnt <= '0;
        res_cnt  <= '0;
        out_cnt  <= '0;
        sof_flag <= 1'b0;
      end else begin
        if (req_hs) begin
          feed_cnt <= feed_cnt + 4'd1;
        end
        if (req_hs && (state == ROW_PASS) && (feed_cnt == 4'd0)) begin
          sof_flag <= video_i_tuser;
        end
        if (res_hs && (state == ROW_PASS)) begin
          res_cnt <= res_cnt + 6'd1;
        end
        if (coef_hs) begin
          out_cnt <= out_cnt + 6'd1;
        end
      end
    end
  end

  // Row results land at [row][word]; the buffer is frozen during the column pass.
  always_ff @(posedge clk_i) begin
    if ((state == ROW_PASS) && res_hs) begin
      tbuf[res_cnt[5:3]][res_cnt[2:0]] <= dct_res_i_tdata;
    end
  end

endmodule

// File: tb/tb_dct_2d_sched.sv
// Bench for dct_2d_sched: acts as the shared 1D transform and checks the coefficient
// stream against a block-level transpose model, with directed tables and random stalls.
module tb_dct_2d_sched;

  typedef struct {
    logic [63:0] data;
    logic        user;
  } vbeat_t;

  typedef struct {
    int          pat;
    int          mode;
    logic        sof;
    logic [15:0] exp_c0;
    int          exp_nz;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  v_data;
  logic         v_valid, v_user, v_ready;
  logic [127:0] req_data;
  logic         req_valid, req_ready;
  logic [15:0]  res_data;
  logic         res_valid, res_ready;
  logic [15:0]  coef_data;
  logic         coef_valid, coef_last, coef_user, coef_ready;

  int total, bad;
  int stub_mode;
  int p_vvalid, p_req_ready, p_coef_ready;
  int rows_fed, col_fed, row_res, coef_out, tlast_cnt, tuser_cnt;
  logic in_col, vdone;

  vbeat_t      vq[$];
  logic [15:0] sq[$];
  logic [15:0] eq_d[$];
  logic        eq_l[$];
  logic        eq_u[$];
  logic [15:0] cap[$];
  logic [15:0] ref_cap[$];
  logic [7:0]  pix [8][8];
  logic [7:0]  saved [2][8][8];
  vec_t        tv [5];

  dct_2d_sched #(.PX_WIDTH(8), .DCT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .video_i_tdata(v_data), .video_i_tvalid(v_valid), .video_i_tuser(v_user),
    .video_i_tready(v_ready),
    .dct_req_o_tdata(req_data), .dct_req_o_tvalid(req_valid), .dct_req_o_tready(req_ready),
    .dct_res_i_tdata(res_data), .dct_res_i_tvalid(res_valid), .dct_res_i_tready(res_ready),
    .coef_o_tdata(coef_data), .coef_o_tvalid(coef_valid), .coef_o_tlast(coef_last),
    .coef_o_tuser(coef_user), .coef_o_tready(coef_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] sext8(input logic [7:0] p);
    return {{8{p[7]}}, p};
  endfunction

  // 1D stand-in: mode 0 echoes lane k; mode 1 gives the lane sum then neighbour differences.
  function automatic logic [15:0] t1d(input logic [127:0] v, input int k);
    logic [15:0] s;
    s = 16'd0;
    if (stub_mode == 0) return v[k*16 +: 16];
    if (k == 0) begin
      for (int i = 0; i < 8; i++) s = s + v[i*16 +: 16];
      return s;
    end
    return v[k*16 +: 16] - v[(k-1)*16 +: 16];
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (pat)
          0:       pix[r][c] = 8'(8*r + c);
          1:       pix[r][c] = 8'd0;
          2:       pix[r][c] = 8'd10;
          3:       pix[r][c] = 8'hFF;
          default: pix[r][c] = 8'($urandom);
        endcase
  endtask

  // Queue one block of pix and the 64 coefficients it must produce, column-major.
  task automatic queue_block(input logic sof);
    logic [63:0]  d;
    logic [127:0] vec;
    logic [15:0]  rr [8][8];
    for (int r = 0; r < 8; r++) begin
      d = '0;
      vec = '0;
      for (int c = 0; c < 8; c++) begin
        d[c*8 +: 8]    = pix[r][c];
        vec[c*16 +: 16] = sext8(pix[r][c]);
      end
      vq.push_back('{d, (sof && (r == 0))});
      for (int k = 0; k < 8; k++) rr[r][k] = t1d(vec, k);
    end
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) vec[i*16 +: 16] = rr[i][j];
      for (int u = 0; u < 8; u++) begin
        eq_d.push_back(t1d(vec, u));
        eq_l.push_back((j == 7) && (u == 7));
        eq_u.push_back(sof && (j == 0) && (u == 0));
      end
    end
  endtask

  task automatic step();
    logic [127:0] ext;
    logic vhs, reqhs, reshs, chs, col_now;
    @(negedge clk);
    if (!v_valid || vdone) begin
      v_valid = (vq.size() != 0) && (int'($urandom_range(99)) < p_vvalid);
      vdone = 1'b0;
    end
    if (v_valid) begin
      v_data = vq[0].data;
      v_user = vq[0].user;
    end else begin
      v_user = 1'b0;
    end
    res_valid  = (sq.size() != 0);
    res_data   = res_valid ? sq[0] : 16'd0;
    req_ready  = int'($urandom_range(99)) < p_req_ready;
    coef_ready = int'($urandom_range(99)) < p_coef_ready;
    #1;
    col_now = in_col;
    chk("video_ready", v_ready, (!col_now && rows_fed < 8) ? req_ready : 1'b0);
    chk("req_valid", req_valid, col_now ? (col_fed < 8) : (rows_fed < 8 && v_valid));
    chk("res_ready", res_ready, col_now ? coef_ready : 1'b1);
    chk("coef_valid", coef_valid, col_now ? res_valid : 1'b0);
    if (!col_now && req_valid) begin
      for (int c = 0; c < 8; c++) ext[c*16 +: 16] = sext8(v_data[c*8 +: 8]);
      chk("req_lanes", {16'd0, 16'(req_data != ext)}, 32'd0);
    end
    vhs   = v_valid && v_ready;
    reqhs = req_valid && req_ready;
    reshs = res_valid && res_ready;
    chs   = coef_valid && coef_ready;
    if (reqhs) begin
      for (int k = 0; k < 8; k++) sq.push_back(t1d(req_data, k));
      if (col_now) col_fed++;
    end
    if (vhs) begin
      void'(vq.pop_front());
      rows_fed++;
      vdone = 1'b1;
    end
    if (reshs) void'(sq.pop_front());
    if (reshs && !col_now) begin
      row_res++;
      if (row_res == 64) begin
        in_col  = 1'b1;
        col_fed = 0;
      end
    end
    if (chs) begin
      total++;
      if (eq_d.size() == 0) begin
        bad++;
        $display("FAIL extra_coef got=%0h exp=none", coef_data);
      end else begin
        total--;
        chk("coef_data", coef_data, eq_d.pop_front());
        chk("coef_last", coef_last, eq_l.pop_front());
        chk("coef_user", coef_user, eq_u.pop_front());
      end
      cap.push_back(coef_data);
      tlast_cnt += int'(coef_last);
      tuser_cnt += int'(coef_user);
      coef_out++;
      if (coef_out == 64) begin
        in_col   = 1'b0;
        rows_fed = 0;
        row_res  = 0;
        coef_out = 0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((vq.size() != 0 || eq_d.size() != 0) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (vq.size() != 0 || eq_d.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout rows_left=%0d coefs_left=%0d exp=0", vq.size(), eq_d.size());
    end
  endtask

  task automatic clear_model();
    vq.delete(); sq.delete(); eq_d.delete(); eq_l.delete(); eq_u.delete(); cap.delete();
    rows_fed = 0; col_fed = 0; row_res = 0; coef_out = 0; in_col = 1'b0;
    tlast_cnt = 0; tuser_cnt = 0; vdone = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v_valid = 1'b0;
    res_valid = 1'b1;
    res_data = 16'h1234;
    coef_ready = 1'b1;
    clear_model();
    #1;
    chk("rst_coef_valid", coef_valid, 1'b0);
    chk("rst_req_valid", req_valid, 1'b0);
    repeat (2) @(negedge clk);
    res_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    total = 0; bad = 0; stub_mode = 0;
    p_vvalid = 100; p_req_ready = 100; p_coef_ready = 100;
    rst = 1'b1; v_data = '0; v_valid = 1'b0; v_user = 1'b0; req_ready = 1'b0;
    res_data = '0; res_valid = 1'b0; coef_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    v_valid = 1'b1; v_user = 1'b1; req_ready = 1'b1; coef_ready = 1'b1;
    #1;
    chk("reset_video_ready", v_ready, 1'b0);
    chk("reset_req_valid", req_valid, 1'b0);
    chk("reset_coef_valid", coef_valid, 1'b0);
    chk("reset_coef_last", coef_last, 1'b0);
    chk("reset_coef_user", coef_user, 1'b0);
    @(negedge clk);
    rst = 1'b0; v_valid = 1'b0; v_user = 1'b0;
    #1;
    chk("ready_follow_hi", v_ready, 1'b1);
    req_ready = 1'b0;
    #1;
    chk("ready_follow_lo", v_ready, 1'b0);

    // Directed blocks with hand-derived DC value and nonzero count.
    tv[0] = '{0, 0, 1'b1, 16'd0,    63};
    tv[1] = '{1, 1, 1'b0, 16'd0,    0};
    tv[2] = '{2, 1, 1'b1, 16'd640,  1};
    tv[3] = '{3, 1, 1'b0, 16'hFFC0, 1};
    tv[4] = '{0, 1, 1'b1, 16'd2016, 15};
    for (int t = 0; t < 5; t++) begin
      stub_mode = tv[t].mode;
      cap.delete(); tlast_cnt = 0; tuser_cnt = 0;
      fill(tv[t].pat);
      queue_block(tv[t].sof);
      drain(1000);
      n = 0;
      foreach (cap[i]) if (cap[i] != 16'd0) n++;
      chk("tbl_count", cap.size(), 64);
      chk("tbl_c0", (cap.size() != 0) ? cap[0] : 16'hDEAD, tv[t].exp_c0);
      chk("tbl_nonzero", n, tv[t].exp_nz);
      chk("tbl_tlast", tlast_cnt, 1);
      chk("tbl_tuser", tuser_cnt, int'(tv[t].sof));
    end

    // Frame start on block A only.
    stub_mode = 0; cap.delete(); tlast_cnt = 0; tuser_cnt = 0;
    fill(4); queue_block(1'b1);
    fill(4); queue_block(1'b0);
    drain(2000);
    chk("sof_pulses", tuser_cnt, 1);
    chk("sof_first", (cap.size() == 128) ? 1 : 0, 1);

    // Same two blocks without and with random stalls must give the same stream.
    stub_mode = 1;
    for (int b = 0; b < 2; b++) begin
      fill(4);
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) saved[b][r][c] = pix[r][c];
    end
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        p_vvalid = 60; p_req_ready = 70; p_coef_ready = 50;
      end
      cap.delete();
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix[r][c] = saved[b][r][c];
        queue_block(1'(b == 0));
      end
      drain(4000);
      if (pass == 0) ref_cap = cap;
    end
    chk("stall_len", cap.size(), ref_cap.size());
    for (int i = 0; i < 128; i++)
      chk("stall_seq", (i < cap.size()) ? cap[i] : 16'hDEAD, (i < ref_cap.size()) ? ref_cap[i] : 16'hBEEF);

    // Reset after three column vectors, then a clean fresh block.
    fill(4); queue_block(1'b1);
    n = 0;
    while (!(in_col && col_fed >= 3) && n < 2000) begin
      step();
      n++;
    end
    chk("reach_col3", (in_col && col_fed >= 3) ? 1 : 0, 1);
    do_reset();
    fill(4); queue_block(1'b0);
    drain(3000);
    repeat (40) step();
    chk("post_reset_count", cap.size(), 64);
    chk("post_reset_tlast", tlast_cnt, 1);

    // Four back-to-back blocks through the echo stub.
    stub_mode = 0; cap.delete(); tlast_cnt = 0; tuser_cnt = 0;
    p_vvalid = 80; p_req_ready = 80; p_coef_ready = 80;
    for (int b = 0; b < 4; b++) begin
      fill(4);
      queue_block(1'(b == 0));
    end
    drain(8000);
    chk("b2b_count", cap.size(), 256);
    chk("b2b_tlast", tlast_cnt, 4);
    chk("b2b_tuser", tuser_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
